aquila_data_initiator: RTL and testbench

- Synthesizable data-port initiator for fuzzing the memory-model side of the Aquila data interface; it stands in for core_top's data master.
- Issues a programmable number of pseudo-random read/write requests with the core's signal set (req, addr, rw, byte_enable, data) and waits for data_ready on each.
- Folds returned read data into a checksum and flags hung responders via a timeout.
- Sits in fuzz harnesses directly facing the responder's data port.

---
 rtl/aquila_data_initiator_if.sv | 36 +++
 rtl/aquila_data_initiator.sv | 219 +++++++++++++++++++++
 tb/tb_aquila_data_initiator.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aquila_data_initiator_if.sv
// Data-port bundle between the Aquila data master and a memory-model responder.
// Latency: none (wires only).
// Backpressure: the responder stalls the master by withholding data_ready_i.
interface aquila_data_initiator_if #(
    parameter int XLEN = 32
);
    logic                data_req_o;
    logic [XLEN-1:0]     data_addr_o;
    logic                data_rw_o;
    logic [XLEN/8-1:0]   data_byte_enable_o;
    logic [XLEN-1:0]     data_o;
    logic                data_ready_i;
    logic [XLEN-1:0]     data_i;

    // Initiator side drives the request and samples the completion.
    modport master (
        output data_req_o,
        output data_addr_o,
        output data_rw_o,
        output data_byte_enable_o,
        output data_o,
        input  data_ready_i,
        input  data_i
    );

    // Responder side observes the request and returns the completion.
    modport slave (
        input  data_req_o,
        input  data_addr_o,
        input  data_rw_o,
        input  data_byte_enable_o,
        input  data_o,
        output data_ready_i,
        output data_i
    );
endinterface

// File: rtl/aquila_data_initiator.sv
// Pseudo-random data-port initiator: issues num_txn_i LFSR-driven requests, checksums read data.
// Latency: request is presented one cycle after ISSUE; at least one req-low cycle between requests.
// Backpressure: each request is held stable until data_ready_i, or aborted after TIMEOUT wait cycles.
module aquila_data_initiator #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] SEED      = 32'h0000_0001,
    parameter logic [31:0] ADDR_MASK = 32'h0000_0FFC,
    parameter int          TIMEOUT   = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [15:0]             num_txn_i,
    aquila_data_initiator_if.master dport,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    timeout_o,
    output logic [15:0]             txn_count_o,
    output logic [XLEN-1:0]         rd_checksum_o
);

    localparam int BW = XLEN / 8;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        TOUT  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            rw_q, rw_d;
    logic [BW-1:0]   be_q, be_d;
    logic [XLEN-1:0] wdat_q, wdat_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tout_q, tout_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     num_q, num_d;
    logic [XLEN-1:0] csum_q, csum_d;
    logic [31:0]     lfsr_q, lfsr_d;
    logic [WW-1:0]   wait_q, wait_d;

    // Request fields decoded from the current LFSR value.
    logic [1:0]      req_off;
    logic [BW-1:0]   req_be;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdat;
    logic [31:0]     lfsr_next;
    logic [XLEN-1:0] rd_mask;
    logic            more_txn;

    // Decode size/offset/lane enables from the LFSR; word accesses are always aligned.
    always_comb begin
        req_off = 2'd0;
        req_be  = '1;
        unique case (lfsr_q[2:1])
            2'd0: begin
                req_off = lfsr_q[4:3];
                req_be  = BW'(1) << req_off;
            end
            2'd1: begin
                req_off = {lfsr_q[4], 1'b0};
                req_be  = BW'(3) << req_off;
            end
            default: begin
                req_off = 2'd0;
                req_be  = '1;
            end
        endcase
        req_addr  = XLEN'(lfsr_q & ADDR_MASK) | XLEN'(req_off);
        req_wdat  = XLEN'({lfsr_q[15:0], lfsr_q[31:16]});
        lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
        more_txn  = ({1'b0, cnt_q} + 17'd1) < {1'b0, num_q};
    end

    // Expand the held lane enables into a bit mask so disabled lanes never reach the checksum.
    always_comb begin
        rd_mask = '0;
        for (int i = 0; i < BW; i++) begin
            rd_mask[i*8 +: 8] = {8{be_q[i]}};
        end
    end

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        be_d    = be_q;
        wdat_d  = wdat_q;
        busy_d  = busy_q;
        done_d  = done_q;
        tout_d  = tout_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        csum_d  = csum_q;
        lfsr_d  = lfsr_q;
        wait_d  = wait_q;

        unique case (state_q)
            IDLE, DONE, TOUT: begin
                if (start_i) begin
                    done_d = 1'b0;
                    tout_d = 1'b0;
                    cnt_d  = '0;
                    csum_d = '0;
                    lfsr_d = SEED;
                    num_d  = num_txn_i;
                    if (num_txn_i == 16'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ISSUE;
                        busy_d  = 1'b1;
                        wait_d  = '0;
                    end
                end
            end

            // Latch the request; req rises as WAIT is entered.
            ISSUE: begin
                req_d   = 1'b1;
                addr_d  = req_addr;
                rw_d    = lfsr_q[0];
                be_d    = req_be;
                wdat_d  = req_wdat;
                state_d = WAIT;
            end

            WAIT: begin
                if (dport.data_ready_i) begin
                    req_d  = 1'b0;
                    cnt_d  = cnt_q + 16'd1;
                    lfsr_d = lfsr_next;
                    if (!rw_q) begin
                        csum_d = {csum_q[XLEN-2:0], csum_q[XLEN-1]} ^ (dport.data_i & rd_mask);
                    end
                    if (more_txn) begin
                        state_d = ISSUE;
                        wait_d  = '0;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else if (wait_q == WW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle without a response: give up.
                    state_d = TOUT;
                    req_d   = 1'b0;
                    tout_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Single state/output register bank with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            be_q    <= '0;
            wdat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
            cnt_q   <= '0;
            num_q   <= '0;
            csum_q  <= '0;
            lfsr_q  <= SEED;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            be_q    <= be_d;
            wdat_q  <= wdat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            csum_q  <= csum_d;
            lfsr_q  <= lfsr_d;
            wait_q  <= wait_d;
        end
    end

    assign dport.data_req_o         = req_q;
    assign dport.data_addr_o        = addr_q;
    assign dport.data_rw_o          = rw_q;
    assign dport.data_byte_enable_o = be_q;
    assign dport.data_o             = wdat_q;
    assign busy_o                   = busy_q;
    assign done_o                   = done_q;
    assign timeout_o                = tout_q;
    assign txn_count_o              = cnt_q;
    assign rd_checksum_o            = csum_q;

endmodule

// File: tb/tb_aquila_data_initiator.sv
// Bench for aquila_data_initiator: scoreboarded request sequence, checksum model, timeout and reset cases.
// Latency: responses are returned after a per-test number of wait cycles.
// Backpressure: the bench acts as the responder and withholds data_ready_i to stall.
module tb_aquila_data_initiator;

    localparam int          XLEN = 32;
    localparam logic [31:0] SEED = 32'h0000_0001;
    localparam logic [31:0] MASK = 32'h0000_0FFC;
    localparam int          TO   = 255;

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [3:0]  be;
        logic [31:0] dat;
    } req_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num   = 16'd0;
    logic        busy, done, tout;
    logic [15:0] cnt;
    logic [31:0] csum;

    int   checks = 0;
    int   passes = 0;
    req_t exp_q[$];
    req_t seen[0:1];
    logic [31:0] m_csum;

    aquila_data_initiator_if #(.XLEN(XLEN)) dif ();

    aquila_data_initiator #(
        .XLEN      (XLEN),
        .SEED      (SEED),
        .ADDR_MASK (MASK),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .num_txn_i     (num),
        .dport         (dif.master),
        .busy_o        (busy),
        .done_o        (done),
        .timeout_o     (tout),
        .txn_count_o   (cnt),
        .rd_checksum_o (csum)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    endfunction

    function automatic req_t mk_req(input logic [31:0] l);
        req_t       r;
        logic [1:0] off;
        logic [3:0] one;
        logic [3:0] two;
        one  = 4'b0001;
        two  = 4'b0011;
        r.rw = l[0];
        case (l[2:1])
            2'd0:    begin off = l[4:3];        r.be = one << off; end
            2'd1:    begin off = {l[4], 1'b0};  r.be = two << off; end
            default: begin off = 2'd0;          r.be = 4'hF;       end
        endcase
        r.addr = (l & MASK) | {30'd0, off};
        r.dat  = {l[15:0], l[31:16]};
        return r;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
        return m;
    endfunction

    task automatic pulse_start(input int n);
        @(negedge clk);
        start = 1'b1;
        num   = n[15:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs n transactions as the responder; dly<0 means random 0..4 wait cycles.
    task automatic run(input int n, input int dly, input int abort_at);
        req_t        e;
        logic [31:0] l;
        logic [31:0] rd;
        int          w;
        int          d;
        exp_q.delete();
        m_csum = 32'd0;
        l = SEED;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk_req(l));
            l = lfsr_step(l);
        end
        pulse_start(n);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || tout !== 1'b0 || cnt !== 16'd0 || csum !== 32'd0)
            $display("FAIL start_state: busy=%b done=%b tout=%b cnt=%0d csum=%h, want 1 0 0 0 0",
                     busy, done, tout, cnt, csum);
        else passes++;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (dif.data_req_o !== 1'b1 && w < 50) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (dif.data_req_o !== 1'b1) begin
                $display("FAIL req_wait: txn %0d req=%b after %0d cycles, want 1", i, dif.data_req_o, w);
                return;
            end
            passes++;
            e = exp_q.pop_front();
            if (i < 2) begin
                seen[i].addr = dif.data_addr_o;
                seen[i].rw   = dif.data_rw_o;
                seen[i].be   = dif.data_byte_enable_o;
                seen[i].dat  = dif.data_o;
            end
            checks++;
            if (dif.data_addr_o !== e.addr || dif.data_rw_o !== e.rw ||
                dif.data_byte_enable_o !== e.be || dif.data_o !== e.dat)
                $display("FAIL req_fields: txn %0d got addr=%h rw=%b be=%b dat=%h, want addr=%h rw=%b be=%b dat=%h",
                         i, dif.data_addr_o, dif.data_rw_o, dif.data_byte_enable_o, dif.data_o,
                         e.addr, e.rw, e.be, e.dat);
            else passes++;
            if (i == abort_at) begin
                #1 rst_n = 1'b0;
                #1;
                checks++;
                if (dif.data_req_o !== 1'b0 || dif.data_addr_o !== 32'd0 || dif.data_rw_o !== 1'b0 ||
                    dif.data_byte_enable_o !== 4'd0 || dif.data_o !== 32'd0 || busy !== 1'b0 ||
                    done !== 1'b0 || tout !== 1'b0 || cnt !== 16'd0 || csum !== 32'd0)
                    $display("FAIL async_reset: req=%b addr=%h busy=%b done=%b cnt=%0d csum=%h, want all 0",
                             dif.data_req_o, dif.data_addr_o, busy, done, cnt, csum);
                else passes++;
                @(negedge clk);
                rst_n = 1'b1;
                exp_q.delete();
                return;
            end
            d = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
            repeat (d) @(negedge clk);
            checks++;
            if (dif.data_req_o !== 1'b1 || dif.data_addr_o !== e.addr || dif.data_o !== e.dat ||
                dif.data_byte_enable_o !== e.be || dif.data_rw_o !== e.rw || busy !== 1'b1)
                $display("FAIL req_stable: txn %0d req=%b addr=%h dat=%h busy=%b, want 1 %h %h 1",
                         i, dif.data_req_o, dif.data_addr_o, dif.data_o, busy, e.addr, e.dat);
            else passes++;
            rd = $urandom;
            dif.data_i       = rd;
            dif.data_ready_i = 1'b1;
            if (!e.rw) m_csum = {m_csum[30:0], m_csum[31]} ^ (rd & lane_mask(e.be));
            @(negedge clk);
            dif.data_ready_i = 1'b0;
            checks++;
            if (dif.data_req_o !== 1'b0 || cnt !== 16'(i + 1) || csum !== m_csum)
                $display("FAIL post_ready: txn %0d req=%b cnt=%0d csum=%h, want 0 %0d %h",
                         i, dif.data_req_o, cnt, csum, i + 1, m_csum);
            else passes++;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || tout !== 1'b0 || cnt !== 16'(n) || csum !== m_csum)
            $display("FAIL run_end: done=%b busy=%b tout=%b cnt=%0d csum=%h, want 1 0 0 %0d %h",
                     done, busy, tout, cnt, csum, n, m_csum);
        else passes++;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (dif.data_req_o !== 1'b0 || dif.data_addr_o !== 32'd0 || dif.data_rw_o !== 1'b0 ||
            dif.data_byte_enable_o !== 4'd0 || dif.data_o !== 32'd0 || busy !== 1'b0 ||
            done !== 1'b0 || tout !== 1'b0 || cnt !== 16'd0 || csum !== 32'd0)
            $display("FAIL reset_state: req=%b addr=%h busy=%b done=%b tout=%b cnt=%0d csum=%h, want all 0",
                     dif.data_req_o, dif.data_addr_o, busy, done, tout, cnt, csum);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        // Stray completions while idle must be ignored.
        dif.data_i       = 32'hFFFF_FFFF;
        dif.data_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        dif.data_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (cnt !== 16'd0 || csum !== 32'd0 || busy !== 1'b0 || dif.data_req_o !== 1'b0)
            $display("FAIL idle_stray_ready: cnt=%0d csum=%h busy=%b req=%b, want 0 0 0 0",
                     cnt, csum, busy, dif.data_req_o);
        else passes++;
    endtask

    task automatic test_single;
        run(1, 3, -1);
        checks++;
        if (seen[0].addr !== 32'h0 || seen[0].rw !== 1'b1 || seen[0].be !== 4'b0001 ||
            seen[0].dat !== 32'h0001_0000)
            $display("FAIL first_req: addr=%h rw=%b be=%b dat=%h, want 00000000 1 0001 00010000",
                     seen[0].addr, seen[0].rw, seen[0].be, seen[0].dat);
        else passes++;
    endtask

    task automatic test_back_to_back;
        run(2, 1, -1);
        checks++;
        if (seen[1].addr !== 32'h0 || seen[1].rw !== 1'b1 || seen[1].be !== 4'b0011 ||
            seen[1].dat !== 32'h0003_8020)
            $display("FAIL second_req: addr=%h rw=%b be=%b dat=%h, want 00000000 1 0011 00038020",
                     seen[1].addr, seen[1].rw, seen[1].be, seen[1].dat);
        else passes++;
    endtask

    task automatic test_checksum;
        run(24, -1, -1);
    endtask

    task automatic test_stray_done;
        logic [31:0] c0;
        c0 = m_csum;
        dif.data_i       = 32'hA5A5_5A5A;
        dif.data_ready_i = 1'b1;
        repeat (4) @(negedge clk);
        dif.data_ready_i = 1'b0;
        checks++;
        if (cnt !== 16'd24 || csum !== c0 || done !== 1'b1 || dif.data_req_o !== 1'b0)
            $display("FAIL done_stray_ready: cnt=%0d csum=%h done=%b req=%b, want 24 %h 1 0",
                     cnt, csum, done, dif.data_req_o, c0);
        else passes++;
    endtask

    task automatic test_timeout;
        int w;
        int hi;
        pulse_start(3);
        w = 0;
        while (dif.data_req_o !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        hi = 0;
        while (dif.data_req_o === 1'b1 && hi < 400) begin
            hi++;
            @(negedge clk);
        end
        checks++;
        if (hi !== TO)
            $display("FAIL timeout_len: req high %0d cycles, want %0d", hi, TO);
        else passes++;
        checks++;
        if (tout !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cnt !== 16'd0)
            $display("FAIL timeout_flags: tout=%b busy=%b done=%b cnt=%0d, want 1 0 0 0",
                     tout, busy, done, cnt);
        else passes++;
    endtask

    task automatic test_zero;
        int rose;
        pulse_start(0);
        checks++;
        if (done !== 1'b1 || tout !== 1'b0 || busy !== 1'b0 || cnt !== 16'd0 || csum !== 32'd0)
            $display("FAIL zero_txn: done=%b tout=%b busy=%b cnt=%0d csum=%h, want 1 0 0 0 0",
                     done, tout, busy, cnt, csum);
        else passes++;
        rose = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dif.data_req_o === 1'b1) rose++;
        end
        checks++;
        if (rose !== 0)
            $display("FAIL zero_no_req: req high on %0d cycles, want 0", rose);
        else passes++;
    endtask

    task automatic test_midrun_reset;
        run(10, 1, 4);
        checks++;
        if (busy !== 1'b0 || cnt !== 16'd0 || dif.data_req_o !== 1'b0)
            $display("FAIL post_reset_idle: busy=%b cnt=%0d req=%b, want 0 0 0", busy, cnt, dif.data_req_o);
        else passes++;
        run(10, 0, -1);
    endtask

    initial begin
        dif.data_ready_i = 1'b0;
        dif.data_i       = 32'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_checksum();
        test_stray_done();
        test_timeout();
        test_zero();
        test_midrun_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
